memory_bus_arbiter: RTL and testbench

//  Shares a single main-memory port between the instruction cache (read-only) and data cache (read/write).

---
 rtl/memory_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: shares one main-memory port between the instruction
// cache (read-only) and the data cache (read/write). One requester is granted
// at a time. Memory strobes are held until memory completes, then dropped for
// one RELEASE cycle. A per-grant watchdog raises a sticky ERR.
// Optional build macro: ARB_ROUND_ROBIN_EN. When it is defined, simultaneous
// requests alternate with the side granted last. When it is undefined, the
// data cache always wins over the instruction cache.
module memory_bus_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int BLK_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [BLK_W-1:0]  I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [BLK_W-1:0]  D_WRITEDATA,
  output logic [BLK_W-1:0]  D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLK_W-1:0]  MEM_WRITEDATA,
  input  logic [BLK_W-1:0]  MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              ERR
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          state, state_next;
  logic            started;
  logic [TW-1:0]   timer;
  logic [BLK_W-1:0] i_data_q, d_data_q;

  logic i_req, d_req, in_grant, gnt_req, done;
  logic i_done, d_done, timer_max, timeout_fire, pick_d;

  assign i_req    = I_READ;
  assign d_req    = D_READ | D_WRITE;
  assign in_grant = (state == GRANT_I) || (state == GRANT_D);
  assign gnt_req  = (state == GRANT_I) ? i_req : d_req;
  assign done     = started & ~MEM_BUSYWAIT;

  // Completion only counts while the granted side still requests; a dropped
  // request in the same cycle is an abort and returns no data.
  assign i_done = (state == GRANT_I) & done & i_req;
  assign d_done = (state == GRANT_D) & done & d_req;

  assign timer_max    = in_grant && (timer == TW'(TIMEOUT - 1));
  assign timeout_fire = timer_max & gnt_req & ~done;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d;
  assign pick_d = d_req & (~i_req | ~last_grant_d);
`else
  assign pick_d = d_req;
`endif

  assign I_BUSYWAIT = i_req & ~i_done;
  assign D_BUSYWAIT = d_req & ~d_done;
  assign I_READDATA = i_done ? MEM_READDATA : i_data_q;
  assign D_READDATA = d_done ? MEM_READDATA : d_data_q;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: arbitration in IDLE, leave a grant on done/abort/timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_d)     state_next = GRANT_D;
        else if (i_req) state_next = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (done | ~gnt_req | timer_max) state_next = RELEASE;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered memory interface, watchdog, progress tracking and held read data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      ERR           <= 1'b0;
      started       <= 1'b0;
      timer         <= '0;
      i_data_q      <= '0;
      d_data_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d  <= 1'b1;
`endif
    end else begin
      if (in_grant) begin
        timer <= timer + TW'(1);
        if (MEM_BUSYWAIT) started <= 1'b1;
      end
      if (state == IDLE && state_next == GRANT_D) begin
        MEM_ADDRESS   <= D_ADDRESS;
        MEM_WRITEDATA <= D_WRITEDATA;
        MEM_WRITE     <= D_WRITE;
        MEM_READ      <= ~D_WRITE;
      end else if (state == IDLE && state_next == GRANT_I) begin
        MEM_ADDRESS <= I_ADDRESS;
        MEM_READ    <= 1'b1;
        MEM_WRITE   <= 1'b0;
      end
      if (state_next == RELEASE) begin
        MEM_READ  <= 1'b0;
        MEM_WRITE <= 1'b0;
        started   <= 1'b0;
        timer     <= '0;
      end
      if (i_done) i_data_q <= MEM_READDATA;
      if (d_done) d_data_q <= MEM_READDATA;
`ifdef ARB_ROUND_ROBIN_EN
      if (i_done) last_grant_d <= 1'b0;
      if (d_done) last_grant_d <= 1'b1;
`endif
      if (timeout_fire) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed self-checking bench for memory_bus_arbiter. Each scenario task drives
// the cache and memory sides by hand and compares the ports against
// hand-computed values. Inputs change 1ns after the rising edge. Checks take
// place 1ns after the inputs settle.
module tb_memory_bus_arbiter;

  localparam int ADDR_W = 6;
  localparam int BLK_W  = 32;

  logic              CLK, RESET;
  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDRESS;
  logic [BLK_W-1:0]  I_READDATA;
  logic              I_BUSYWAIT;
  logic              D_READ, D_WRITE;
  logic [ADDR_W-1:0] D_ADDRESS;
  logic [BLK_W-1:0]  D_WRITEDATA, D_READDATA;
  logic              D_BUSYWAIT;
  logic              MEM_READ, MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [BLK_W-1:0]  MEM_WRITEDATA, MEM_READDATA;
  logic              MEM_BUSYWAIT;
  logic              ERR;

  int total = 0;
  int bad   = 0;

  memory_bus_arbiter #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .TIMEOUT(64)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1; I_READ = 1'b0; I_ADDRESS = '0; D_READ = 1'b0; D_WRITE = 1'b0;
    D_ADDRESS = '0; D_WRITEDATA = '0; MEM_READDATA = '0; MEM_BUSYWAIT = 1'b0;
    tick; tick;
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL rst_mem_read got=%b exp=0", MEM_READ); end
    total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL rst_mem_write got=%b exp=0", MEM_WRITE); end
    total++; if (MEM_ADDRESS !== 6'h00) begin bad++; $display("FAIL rst_mem_addr got=%h exp=00", MEM_ADDRESS); end
    total++; if (MEM_WRITEDATA !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", MEM_WRITEDATA); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", ERR); end
    RESET = 1'b0;
    tick;
    total++; if (I_BUSYWAIT !== 1'b0 || D_BUSYWAIT !== 1'b0) begin
      bad++; $display("FAIL rst_busywait got=%b%b exp=00", I_BUSYWAIT, D_BUSYWAIT); end
  endtask

  task automatic test_icache_read;
    I_READ = 1'b1; I_ADDRESS = 6'h05;
    #1;
    total++; if (I_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL t1_busy_rise got=%b exp=1", I_BUSYWAIT); end
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL t1_read_early got=%b exp=0", MEM_READ); end
    tick;
    total++; if (MEM_READ !== 1'b1) begin bad++; $display("FAIL t1_mem_read got=%b exp=1", MEM_READ); end
    total++; if (MEM_ADDRESS !== 6'h05) begin bad++; $display("FAIL t1_mem_addr got=%h exp=05", MEM_ADDRESS); end
    total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL t1_mem_write got=%b exp=0", MEM_WRITE); end
    MEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (I_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL t1_busy_hold[%0d] got=%b exp=1", i, I_BUSYWAIT); end
      tick;
    end
    MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'hCAFEF00D;
    #1;
    total++; if (I_BUSYWAIT !== 1'b0) begin bad++; $display("FAIL t1_busy_done got=%b exp=0", I_BUSYWAIT); end
    total++; if (I_READDATA !== 32'hCAFEF00D) begin bad++; $display("FAIL t1_rdata got=%h exp=cafef00d", I_READDATA); end
    tick;
    I_READ = 1'b0; MEM_READDATA = 32'h0;
    #1;
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL t1_release_read got=%b exp=0", MEM_READ); end
    total++; if (I_READDATA !== 32'hCAFEF00D) begin bad++; $display("FAIL t1_rdata_hold got=%h exp=cafef00d", I_READDATA); end
    tick;
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL t1_idle_read got=%b exp=0", MEM_READ); end
  endtask

  task automatic test_dcache_write;
    D_WRITE = 1'b1; D_ADDRESS = 6'h12; D_WRITEDATA = 32'h11223344;
    #1;
    total++; if (D_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL t2_busy_rise got=%b exp=1", D_BUSYWAIT); end
    tick;
    total++; if (MEM_WRITE !== 1'b1) begin bad++; $display("FAIL t2_mem_write got=%b exp=1", MEM_WRITE); end
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL t2_mem_read got=%b exp=0", MEM_READ); end
    total++; if (MEM_ADDRESS !== 6'h12) begin bad++; $display("FAIL t2_mem_addr got=%h exp=12", MEM_ADDRESS); end
    total++; if (MEM_WRITEDATA !== 32'h11223344) begin bad++; $display("FAIL t2_mem_wdata got=%h exp=11223344", MEM_WRITEDATA); end
    MEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (D_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL t2_busy_hold[%0d] got=%b exp=1", i, D_BUSYWAIT); end
      total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL t2_read_hold[%0d] got=%b exp=0", i, MEM_READ); end
      tick;
    end
    MEM_BUSYWAIT = 1'b0;
    #1;
    total++; if (D_BUSYWAIT !== 1'b0) begin bad++; $display("FAIL t2_busy_done got=%b exp=0", D_BUSYWAIT); end
    tick;
    D_WRITE = 1'b0;
    #1;
    total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL t2_release_write got=%b exp=0", MEM_WRITE); end
    tick;
  endtask

  task automatic test_contention;
    logic              first_d;
    logic [ADDR_W-1:0] a1, a2;
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    a1 = first_d ? 6'h21 : 6'h07;
    a2 = first_d ? 6'h07 : 6'h21;
    I_READ = 1'b1; I_ADDRESS = 6'h07; D_READ = 1'b1; D_ADDRESS = 6'h21;
    #1;
    total++; if (I_BUSYWAIT !== 1'b1 || D_BUSYWAIT !== 1'b1) begin
      bad++; $display("FAIL t3_both_busy got=%b%b exp=11", I_BUSYWAIT, D_BUSYWAIT); end
    tick;
    total++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== a1) begin
      bad++; $display("FAIL t3_first_grant got=%b/%h exp=1/%h", MEM_READ, MEM_ADDRESS, a1); end
    MEM_BUSYWAIT = 1'b1;
    tick;
    MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'hD00D0001;
    #1;
    if (first_d) begin
      total++; if (D_BUSYWAIT !== 1'b0 || D_READDATA !== 32'hD00D0001) begin
        bad++; $display("FAIL t3_first_done got=%b/%h exp=0/d00d0001", D_BUSYWAIT, D_READDATA); end
      total++; if (I_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL t3_other_stall got=%b exp=1", I_BUSYWAIT); end
    end else begin
      total++; if (I_BUSYWAIT !== 1'b0 || I_READDATA !== 32'hD00D0001) begin
        bad++; $display("FAIL t3_first_done got=%b/%h exp=0/d00d0001", I_BUSYWAIT, I_READDATA); end
      total++; if (D_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL t3_other_stall got=%b exp=1", D_BUSYWAIT); end
    end
    tick;
    if (first_d) D_READ = 1'b0; else I_READ = 1'b0;
    #1;
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL t3_release got=%b exp=0", MEM_READ); end
    tick;
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL t3_idle_gap got=%b exp=0", MEM_READ); end
    total++; if ((first_d ? I_BUSYWAIT : D_BUSYWAIT) !== 1'b1) begin
      bad++; $display("FAIL t3_gap_stall got=%b exp=1", first_d ? I_BUSYWAIT : D_BUSYWAIT); end
    tick;
    total++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== a2) begin
      bad++; $display("FAIL t3_second_grant got=%b/%h exp=1/%h", MEM_READ, MEM_ADDRESS, a2); end
    MEM_BUSYWAIT = 1'b1;
    tick;
    MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'h1234ABCD;
    #1;
    total++; if (I_BUSYWAIT !== 1'b0 && D_BUSYWAIT !== 1'b0) begin
      bad++; $display("FAIL t3_second_done got=%b%b exp=one low", I_BUSYWAIT, D_BUSYWAIT); end
    tick;
    I_READ = 1'b0; D_READ = 1'b0;
    tick;
  endtask

  task automatic test_timeout;
    I_READ = 1'b1; I_ADDRESS = 6'h3F;
    tick;
    MEM_BUSYWAIT = 1'b1;
    #1;
    total++; if (MEM_READ !== 1'b1) begin bad++; $display("FAIL t4_grant got=%b exp=1", MEM_READ); end
    for (int i = 1; i <= 63; i++) begin
      tick;
      total++; if (ERR !== 1'b0 || MEM_READ !== 1'b1) begin
        bad++; $display("FAIL t4_pre_timeout[%0d] err=%b read=%b exp=0/1", i, ERR, MEM_READ); end
    end
    tick;
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL t4_err_set got=%b exp=1", ERR); end
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL t4_strobe_drop got=%b exp=0", MEM_READ); end
    total++; if (I_BUSYWAIT !== 1'b1) begin bad++; $display("FAIL t4_still_stalled got=%b exp=1", I_BUSYWAIT); end
    tick;
    total++; if (MEM_READ !== 1'b0 || ERR !== 1'b1) begin
      bad++; $display("FAIL t4_idle read=%b err=%b exp=0/1", MEM_READ, ERR); end
    tick;
    total++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h3F) begin
      bad++; $display("FAIL t4_rearb got=%b/%h exp=1/3f", MEM_READ, MEM_ADDRESS); end
    I_READ = 1'b0; MEM_BUSYWAIT = 1'b0;
    tick;
    tick;
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL t4_err_sticky got=%b exp=1", ERR); end
  endtask

  task automatic test_reset_mid;
    D_WRITE = 1'b1; D_ADDRESS = 6'h2A; D_WRITEDATA = 32'hDEADBEEF;
    tick;
    MEM_BUSYWAIT = 1'b1;
    tick; tick;
    total++; if (MEM_WRITE !== 1'b1) begin bad++; $display("FAIL t5_in_grant got=%b exp=1", MEM_WRITE); end
    RESET = 1'b1;
    tick;
    total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL t5_write_clr got=%b exp=0", MEM_WRITE); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL t5_err_clr got=%b exp=0", ERR); end
    total++; if (MEM_ADDRESS !== 6'h00) begin bad++; $display("FAIL t5_addr_clr got=%h exp=00", MEM_ADDRESS); end
    RESET = 1'b0; D_WRITE = 1'b0; MEM_BUSYWAIT = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    D_READ = 1'b1; D_ADDRESS = 6'h0B;
    tick;
    total++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h0B) begin
      bad++; $display("FAIL t6_grant got=%b/%h exp=1/0b", MEM_READ, MEM_ADDRESS); end
    MEM_BUSYWAIT = 1'b1; MEM_READDATA = 32'h55AA55AA;
    tick;
    D_READ = 1'b0;
    #1;
    total++; if (D_BUSYWAIT !== 1'b0) begin bad++; $display("FAIL t6_busy_drop got=%b exp=0", D_BUSYWAIT); end
    tick;
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL t6_release got=%b exp=0", MEM_READ); end
    total++; if (D_READDATA !== 32'h0) begin bad++; $display("FAIL t6_rdata_keep got=%h exp=0", D_READDATA); end
    MEM_BUSYWAIT = 1'b0;
    I_READ = 1'b1; I_ADDRESS = 6'h19;
    tick;
    total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL t6_idle got=%b exp=0", MEM_READ); end
    tick;
    total++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h19) begin
      bad++; $display("FAIL t6_next_grant got=%b/%h exp=1/19", MEM_READ, MEM_ADDRESS); end
    I_READ = 1'b0;
    tick; tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_icache_read;
    test_dcache_write;
    test_contention;
    test_timeout;
    test_reset_mid;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
